// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants and write-back entry type
package fpu_pkg;

  localparam int FPU_DATA_W = 32;
  localparam int FPU_RA_W   = 4;

  typedef struct packed {
    logic                  valid;
    logic [FPU_RA_W-1:0]   wa;
    logic [FPU_DATA_W-1:0] data;
  } fpu_wb_entry_t;

endpackage

// File: rtl/wbq_hazard_cmp.sv
// rtl/wbq_hazard_cmp.sv - DEPTH-way pending-destination comparator for one read address
module wbq_hazard_cmp
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RA_W  = FPU_RA_W
) (
  input  logic [DEPTH-1:0]           ent_valid,
  input  logic [DEPTH-1:0][RA_W-1:0] ent_wa,
  input  logic                       push_in,
  input  logic [RA_W-1:0]            push_wa,
  input  logic [RA_W-1:0]            ra,
  output logic                       hit
);

  // A read is hazardous if any queued entry or the result arriving this cycle targets it
  always_comb begin
    hit = push_in & (push_wa == ra);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_wa[i] == ra)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_wb_queue.sv
// rtl/fpu_wb_queue.sv - in-order FPU write-back queue with decode hazard reporting (optional FPU_WBQ_BYPASS_EN)
module fpu_wb_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = FPU_DATA_W,
  parameter int RA_W   = FPU_RA_W
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       PushIn,
  input  logic [DATA_W-1:0]          PushData,
  input  logic [RA_W-1:0]            PushWA3,
  input  logic                       WBPortFree,
  input  logic [RA_W-1:0]            RA1,
  input  logic [RA_W-1:0]            RA2,
  output logic                       WE,
  output logic [RA_W-1:0]            WA,
  output logic [DATA_W-1:0]          WD,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Hazard1,
  output logic                       Hazard2,
  output logic                       Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]           ent_valid;
  logic [DEPTH-1:0][RA_W-1:0] ent_wa;
  logic [DATA_W-1:0]          ent_data [DEPTH];
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count_q;
  logic                       overflow_q;

  logic pop;
  logic push;
  logic drop;
  logic bypass;

  // Queue control: pop when the port is free, push when there is room (a pop frees a slot this cycle)
  always_comb begin
    Empty = (count_q == '0);
    Full  = (count_q == DEPTH_C);
    pop   = !Empty & WBPortFree;
`ifdef FPU_WBQ_BYPASS_EN
    bypass = Empty & PushIn & WBPortFree;
`else
    bypass = 1'b0;
`endif
    push  = PushIn & (!Full | pop) & !bypass;
    drop  = PushIn & Full & !pop;
  end

  // Register-file write port: head entry, or the incoming result when bypassing; zero when idle
  always_comb begin
    WE = pop | bypass;
    WA = '0;
    WD = '0;
    if (pop) begin
      WA = ent_wa[rd_ptr];
      WD = ent_data[rd_ptr];
    end else if (bypass) begin
      WA = PushWA3;
      WD = PushData;
    end
  end

  // Pointers, valid bits, count and sticky overflow; a same-slot push after pop leaves the slot valid
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      ent_valid  <= '0;
      ent_wa     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_wa[wr_ptr]    <= PushWA3;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Result data storage; only read while its valid bit is set, so it needs no reset
  always_ff @(posedge CLK) begin
    if (!Reset && push) begin
      ent_data[wr_ptr] <= PushData;
    end
  end

  assign Count    = count_q;
  assign Overflow = overflow_q;

  wbq_hazard_cmp #(.DEPTH(DEPTH), .RA_W(RA_W)) u_haz1 (
    .ent_valid (ent_valid),
    .ent_wa    (ent_wa),
    .push_in   (PushIn),
    .push_wa   (PushWA3),
    .ra        (RA1),
    .hit       (Hazard1)
  );

  wbq_hazard_cmp #(.DEPTH(DEPTH), .RA_W(RA_W)) u_haz2 (
    .ent_valid (ent_valid),
    .ent_wa    (ent_wa),
    .push_in   (PushIn),
    .push_wa   (PushWA3),
    .ra        (RA2),
    .hit       (Hazard2)
  );

endmodule

// File: tb/tb_fpu_wb_queue.sv
// tb/tb_fpu_wb_queue.sv - self-checking bench for fpu_wb_queue against a queue-based reference model
module tb_fpu_wb_queue;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        Reset;
  logic        PushIn;
  logic [31:0] PushData;
  logic [3:0]  PushWA3;
  logic        WBPortFree;
  logic [3:0]  RA1;
  logic [3:0]  RA2;
  logic        WE;
  logic [3:0]  WA;
  logic [31:0] WD;
  logic        Full;
  logic        Empty;
  logic [2:0]  Count;
  logic        Hazard1;
  logic        Hazard2;
  logic        Overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  fpu_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .RA_W(4)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PushIn     (PushIn),
    .PushData   (PushData),
    .PushWA3    (PushWA3),
    .WBPortFree (WBPortFree),
    .RA1        (RA1),
    .RA2        (RA2),
    .WE         (WE),
    .WA         (WA),
    .WD         (WD),
    .Full       (Full),
    .Empty      (Empty),
    .Count      (Count),
    .Hazard1    (Hazard1),
    .Hazard2    (Hazard2),
    .Overflow   (Overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_bypass();
`ifdef FPU_WBQ_BYPASS_EN
    return (q.size() == 0) && PushIn && WBPortFree;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_haz(input logic [3:0] ra);
    bit h = PushIn && (PushWA3 == ra);
    foreach (q[i]) if (q[i].wa == ra) h = 1'b1;
    return h;
  endfunction

  // Apply inputs, let combinational outputs settle, compare everything against the model
  task automatic drive(input logic rst, input logic push, input logic [31:0] d, input logic [3:0] wa,
                       input logic free, input logic [3:0] r1, input logic [3:0] r2);
    bit pop;
    bit byp;
    Reset = rst; PushIn = push; PushData = d; PushWA3 = wa; WBPortFree = free; RA1 = r1; RA2 = r2;
    #4;
    pop = (q.size() > 0) && free;
    byp = m_bypass();
    chk("we", WE, pop || byp);
    if (pop) begin
      chk("wa", WA, q[0].wa);
      chk("wd", WD, q[0].d);
    end else if (byp) begin
      chk("wa_byp", WA, wa);
      chk("wd_byp", WD, d);
    end
    chk("count", Count, q.size());
    chk("empty", Empty, q.size() == 0);
    chk("full", Full, q.size() == DEPTH);
    chk("ovf", Overflow, m_ovf);
    chk("haz1", Hazard1, m_haz(r1));
    chk("haz2", Hazard2, m_haz(r2));
  endtask

  // Clock edge: advance the model by the queue rules
  task automatic tick();
    bit pop;
    bit byp;
    bit acc;
    ent_t e;
    pop = (q.size() > 0) && WBPortFree;
    byp = m_bypass();
    acc = PushIn && ((q.size() < DEPTH) || pop) && !byp;
    @(posedge CLK);
    if (Reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.wa = PushWA3;
        e.d  = PushData;
        q.push_back(e);
      end
      if (PushIn && !acc && !byp) m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic step(input logic rst, input logic push, input logic [31:0] d, input logic [3:0] wa,
                      input logic free, input logic [3:0] r1, input logic [3:0] r2);
    drive(rst, push, d, wa, free, r1, r2);
    tick();
  endtask

  initial begin
    Reset = 1'b1; PushIn = 1'b0; PushData = '0; PushWA3 = '0; WBPortFree = 1'b0; RA1 = '0; RA2 = '0;
    @(posedge CLK); #1;
    q.delete();

    // Reset then idle with the port free
    step(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_we", WE, 1'b0);
    chk("rst_wa", WA, 4'd0);
    chk("rst_wd", WD, 32'd0);
    tick();

    // Single push, written back next cycle (same cycle with bypass)
    drive(0, 1, 32'h3F80_0000, 4'd5, 1, 0, 0);
`ifdef FPU_WBQ_BYPASS_EN
    chk("byp_we", WE, 1'b1);
    chk("byp_wa", WA, 4'd5);
`else
    chk("single_no_same_cycle", WE, 1'b0);
`endif
    tick();
`ifndef FPU_WBQ_BYPASS_EN
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("single_we", WE, 1'b1);
    chk("single_wa", WA, 4'd5);
    chk("single_wd", WD, 32'h3F80_0000);
    tick();
`endif
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("single_empty", Empty, 1'b1);
    tick();

    // Fill with the port busy, overflow on the fifth push, then drain in order
    step(0, 1, 32'h11, 4'd1, 0, 0, 0);
    step(0, 1, 32'h22, 4'd2, 0, 0, 0);
    step(0, 1, 32'h33, 4'd3, 0, 0, 0);
    step(0, 1, 32'h44, 4'd4, 0, 0, 0);
    drive(0, 1, 32'h66, 4'd6, 0, 0, 0);
    chk("fill_full", Full, 1'b1);
    chk("fill_count", Count, 3'd4);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0); chk("ovf_set", Overflow, 1'b1); chk("drain_wa1", WA, 4'd1); tick();
    drive(0, 0, 0, 0, 1, 0, 0); chk("drain_wa2", WA, 4'd2); tick();
    drive(0, 0, 0, 0, 1, 0, 0); chk("drain_wa3", WA, 4'd3); tick();
    drive(0, 0, 0, 0, 1, 0, 0); chk("drain_wa4", WA, 4'd4); tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("drain_empty", Empty, 1'b1);
    chk("ovf_sticky", Overflow, 1'b1);
    tick();
    step(1, 0, 0, 0, 0, 0, 0);

    // Full queue accepts a push in a cycle it also pops
    for (int i = 0; i < 4; i++) step(0, 1, 32'hA0 + i, 4'(8 + i), 0, 0, 0);
    drive(0, 1, 32'hB0, 4'd13, 1, 0, 0);
    chk("fullpp_we", WE, 1'b1);
    chk("fullpp_wa", WA, 4'd8);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fullpp_count", Count, 3'd4);
    chk("fullpp_ovf", Overflow, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0);

    // Hazards from queued entries and from the incoming push
    step(0, 1, 32'h77, 4'd7, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 4'd7, 4'd2);
    chk("haz_q_h1", Hazard1, 1'b1);
    chk("haz_q_h2", Hazard2, 1'b0);
    tick();
    drive(0, 1, 32'h22, 4'd2, 0, 4'd7, 4'd2);
    chk("haz_push_h2", Hazard2, 1'b1);
    tick();
    drive(0, 0, 0, 0, 1, 4'd7, 4'd2);
    chk("haz_pop_h1", Hazard1, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 4'd7, 4'd2);
    chk("haz_after_h1", Hazard1, 1'b0);
    tick();
    step(0, 0, 0, 0, 1, 0, 0);

    // Reset with a simultaneous push discards everything
    step(0, 1, 32'h1, 4'd1, 0, 0, 0);
    step(0, 1, 32'h2, 4'd2, 0, 0, 0);
    step(0, 1, 32'h3, 4'd3, 0, 0, 0);
    step(1, 1, 32'h4, 4'd4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 4'd1, 4'd4);
    chk("rstmid_count", Count, 3'd0);
    chk("rstmid_we", WE, 1'b0);
    chk("rstmid_h1", Hazard1, 1'b0);
    chk("rstmid_h2", Hazard2, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 2), $urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
